// File: rtl/imem_program_loader.sv
// ----------------------------------------------------------------------------
// imem_program_loader
//   Write-side companion of the instruction memory. Takes a program as a byte
//   stream (valid/ready), packs little-endian 32-bit words and writes them to
//   IMEM. It then pads every remaining word with NOP_WORD and releases the CPU
//   from reset.
//
//   Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes.
//   If IMEM_LOADER_CHECKSUM_EN is defined, one more byte follows the payload.
//   That byte is the XOR of all payload bytes. A mismatch aborts to ERR.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          1-cycle pulse, starts a load from IDLE/DONE/ERR
//   i_rx_data/valid  incoming byte stream
//   o_rx_ready       byte accepted when i_rx_valid & o_rx_ready
//   o_mem_we/waddr/wdata  IMEM write port, one word per strobe
//   o_busy           load in progress
//   o_done / o_err   terminal status levels, held until the next start
//   o_cpu_rst_n      CPU reset release, high only in DONE
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
// ----------------------------------------------------------------------------
module imem_program_loader #(
   parameter int          DEPTH    = 256,
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_cpu_rst_n
);

   // The word index must also hold DEPTH itself, so it is one bit wider than an address.
   localparam int              CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_LO, S_HDR_HI, S_PAYLOAD, S_CHK, S_FILL, S_DONE, S_ERR
   } state_t;

   state_t            r_state, w_next;
   logic [7:0]        r_len_lo;
   logic [CNT_W-1:0]  r_len;
   logic [CNT_W-1:0]  r_widx;
   logic [1:0]        r_lane;
   logic [23:0]       r_pack;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [31:0]       r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
`endif

   logic        w_rx_ready;
   logic        w_acc;
   logic        w_start_ok;
   logic [15:0] w_hdr_len;
   logic        w_len_bad;
   logic        w_pay_done;
   logic        w_fill_end;

   assign w_acc      = i_rx_valid & w_rx_ready;
   assign w_start_ok = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
   assign w_hdr_len  = {i_rx_data, r_len_lo};
   assign w_len_bad  = (w_hdr_len > 16'(DEPTH));
   // The index has caught up with the length, so every payload word has been received.
   assign w_pay_done = (r_widx == r_len);
   assign w_fill_end = (r_widx == DEPTH_C);

`ifndef IMEM_LOADER_CHECKSUM_EN
   logic w_last_byte;
   assign w_last_byte = w_acc & (r_lane == 2'd3) & ((r_widx + CNT_W'(1)) == r_len);
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next state and ready logic
   always_comb begin
      w_next     = r_state;
      w_rx_ready = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (i_start) w_next = S_HDR_LO;
         end
         S_HDR_LO: begin
            w_rx_ready = 1'b1;
            if (w_acc) w_next = S_HDR_HI;
         end
         S_HDR_HI: begin
            w_rx_ready = 1'b1;
            if (w_acc) begin
               if (w_len_bad)            w_next = S_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
               else if (w_hdr_len == '0) w_next = S_CHK;
`else
               else if (w_hdr_len == '0) w_next = S_FILL;
`endif
               else                      w_next = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            w_rx_ready = ~w_pay_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Wait one extra cycle here so the last payload write lands before
            // CHK. CHK itself never writes.
            if (w_pay_done) w_next = S_CHK;
`else
            if (w_last_byte) w_next = S_FILL;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            w_rx_ready = 1'b1;
            if (w_acc) w_next = (i_rx_data == r_csum) ? S_FILL : S_ERR;
         end
`endif
         S_FILL: begin
            if (w_fill_end) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: packing, word index and the registered write port
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_len_lo <= '0;
         r_len    <= '0;
         r_widx   <= '0;
         r_lane   <= '0;
         r_pack   <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum   <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         if (w_start_ok) begin
            r_len  <= '0;
            r_widx <= '0;
            r_lane <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= '0;
`endif
         end
         case (r_state)
            S_HDR_LO: if (w_acc) r_len_lo <= i_rx_data;
            // Truncation is safe: an oversize length goes to ERR and r_len is not used again.
            S_HDR_HI: if (w_acc) r_len <= w_hdr_len[CNT_W-1:0];
            S_PAYLOAD: begin
               if (w_acc) begin
                  r_lane <= r_lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ i_rx_data;
`endif
                  case (r_lane)
                     2'd0: r_pack[7:0]   <= i_rx_data;
                     2'd1: r_pack[15:8]  <= i_rx_data;
                     2'd2: r_pack[23:16] <= i_rx_data;
                     default: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_widx[ADDR_W-1:0];
                        r_wdata <= {i_rx_data, r_pack};
                        r_widx  <= r_widx + CNT_W'(1);
                     end
                  endcase
               end
            end
            S_FILL: begin
               if (!w_fill_end) begin
                  r_we    <= 1'b1;
                  r_waddr <= r_widx[ADDR_W-1:0];
                  r_wdata <= NOP_WORD;
                  r_widx  <= r_widx + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // All outputs come straight from reset-cleared registers, so an asynchronous
   // reset drives them to 0 immediately.
   assign o_rx_ready  = w_rx_ready;
   assign o_mem_we    = r_we;
   assign o_mem_waddr = r_waddr;
   assign o_mem_wdata = r_wdata;
   assign o_busy      = ~((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
   assign o_done      = (r_state == S_DONE);
   assign o_err       = (r_state == S_ERR);
   assign o_cpu_rst_n = (r_state == S_DONE);

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;
   localparam int          DEPTH  = 256;
   localparam int          ADDR_W = 8;
   localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic              clk, rst_n, start, rx_valid, rx_ready;
   logic [7:0]        rx_data;
   logic              mem_we, busy, done, err, cpu_rst_n;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;

   imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rx_data(rx_data),
      .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .o_mem_we(mem_we),
      .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata), .o_busy(busy),
      .o_done(done), .o_err(err), .o_cpu_rst_n(cpu_rst_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
   typedef struct {
      logic [15:0] n; bit fixed; int gap_max; bit stray; bit bad_csum;
      bit exp_done; bit exp_err;
   } vec_t;

   wr_t         exp_q[$];
   vec_t        tbl[$];
   logic [31:0] fixed_w[2];
   int          n_cmp = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every write strobe must match the next expected write.
   always @(negedge clk) begin : mon
      wr_t e;
      if (rst_n && mem_we) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, want no write", mem_waddr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_waddr), 64'(e.addr));
            chk("wr_data", 64'(mem_wdata), 64'(e.data));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All tasks are entered and left one time unit after a rising edge.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      ok = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      rx_valid = 1'b1; rx_data = b;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (rx_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
      end
      rx_valid = 1'b0; rx_data = 8'($urandom);
      chk("byte_accepted", 64'(ok), 64'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
      chk({tag, "_mem_we"},   64'(mem_we), 64'd0);
      chk({tag, "_waddr"},    64'(mem_waddr), 64'd0);
      chk({tag, "_wdata"},    64'(mem_wdata), 64'd0);
      chk({tag, "_busy"},     64'(busy), 64'd0);
      chk({tag, "_done"},     64'(done), 64'd0);
      chk({tag, "_err"},      64'(err), 64'd0);
      chk({tag, "_cpu_rst"},  64'(cpu_rst_n), 64'd0);
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] w[$];
      logic [7:0]  csum, b;
      bit          fin;
      wr_t         e;
      csum = 8'h00;
      if (v.n <= 16'(DEPTH)) begin
         for (int i = 0; i < int'(v.n); i++) begin
            w.push_back(v.fixed ? fixed_w[i] : $urandom);
            e.addr = ADDR_W'(i); e.data = w[i];
            exp_q.push_back(e);
         end
         if (!v.exp_err)
            for (int i = int'(v.n); i < DEPTH; i++) begin
               e.addr = ADDR_W'(i); e.data = NOP;
               exp_q.push_back(e);
            end
      end
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'd1);
      send_byte(v.n[7:0],  $urandom_range(v.gap_max, 0));
      send_byte(v.n[15:8], $urandom_range(v.gap_max, 0));
      if (v.n <= 16'(DEPTH)) begin
         for (int i = 0; i < int'(v.n); i++)
            for (int k = 0; k < 4; k++) begin
               b = w[i][8*k +: 8];
               csum ^= b;
               if (v.stray && i == 0 && k == 1) pulse_start();
               send_byte(b, $urandom_range(v.gap_max, 0));
            end
         if (CSUM_EN) send_byte(v.bad_csum ? (csum ^ 8'h01) : csum, 0);
      end
      fin = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (done || err) begin fin = 1'b1; break; end
      end
      chk("finished_in_time", 64'(fin), 64'd1);
      chk("done",      64'(done), 64'(v.exp_done));
      chk("err",       64'(err),  64'(v.exp_err));
      chk("cpu_rst_n", 64'(cpu_rst_n), 64'(v.exp_done));
      chk("busy_end",  64'(busy), 64'd0);
      chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
      // A byte offered after the load completes must not be taken.
      rx_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("ready_after_end", 64'(rx_ready), 64'd0);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   initial begin
      fixed_w[0] = 32'h0200_0113;
      fixed_w[1] = 32'h4200_0193;
      //              n        fixed gap stray badcs done err
      tbl.push_back('{16'd2,      1, 0, 0, 0, 1, 0});
      tbl.push_back('{16'd0,      0, 0, 0, 0, 1, 0});
      tbl.push_back('{16'd257,    0, 0, 0, 0, 0, 1});
      tbl.push_back('{16'd2,      1, 3, 1, 0, 1, 0});
      tbl.push_back('{16'd256,    0, 0, 0, 0, 1, 0});
      tbl.push_back('{16'd7,      0, 2, 1, 0, 1, 0});
      tbl.push_back('{16'hFFFF,   0, 1, 0, 0, 0, 1});
      tbl.push_back('{16'd1,      0, 1, 0, 0, 1, 0});
      if (CSUM_EN) tbl.push_back('{16'd2, 1, 0, 0, 1, 0, 1});

      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      #12;
      check_outputs_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Finish a load, then start again from DONE: the CPU returns to reset on the next cycle.
      run_vec(tbl[0]);
      pulse_start();
      chk("cpu_rst_after_restart", 64'(cpu_rst_n), 64'd0);
      chk("done_after_restart", 64'(done), 64'd0);
      chk("busy_after_restart", 64'(busy), 64'd1);

      // Reset in the middle of a load. The header goes straight in because the loader is already in HDR_LO.
      begin
         wr_t e;
         e.addr = '0; e.data = 32'hA5C3_1E77;
         exp_q.push_back(e);
         send_byte(8'd4, 0); send_byte(8'd0, 0);
         for (int k = 0; k < 4; k++) send_byte(e.data[8*k +: 8], 0);
         send_byte(8'h5A, 0);
         rx_valid = 1'b1;
         @(negedge clk); #2;
         rst_n = 1'b0;
         #1;
         check_outputs_zero("midrun_reset");
         chk("midrun_q_empty", 64'(exp_q.size()), 64'd0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (20) @(negedge clk);
         chk("post_reset_ready", 64'(rx_ready), 64'd0);
         chk("post_reset_busy",  64'(busy), 64'd0);
         rx_valid = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
